// File: rtl/adder_share_arbiter_pkg.sv
// adder_share_pkg: shared types and constants for the adder sharing arbiter
package adder_share_pkg;
  localparam int ADD_W = 32;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef struct packed {
    logic [ADD_W-1:0] a;
    logic [ADD_W-1:0] b;
    logic cin;
  } add_op_t;
endpackage

// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if: request and response channels of the shared adder
interface adder_share_arbiter_if #(parameter int N_REQ = 4, parameter int WIDTH = 32);
  localparam int ID_W = $clog2(N_REQ);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0] req_cin;
  logic rsp_valid;
  logic rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic rsp_cout;
  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
  modport slave (
    input req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/adder_share_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick starting one past ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input logic [N-1:0] req,
  input logic [IW-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [IW-1:0] grant_idx
);
  // scan from lowest to highest priority so the last hit is the winner
  always_comb begin
    grant = '0;
    grant_idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant = {{(N-1){1'b0}}, 1'b1} << ((int'(ptr) + k) % N);
        grant_idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/prefix_adder_32bit.sv
// prefix_adder_32bit: Kogge-Stone adder with carry-in folded into bit 0
module prefix_adder_32bit (
  input logic cin,
  input logic [31:0] a,
  input logic [31:0] b,
  output logic [31:0] y,
  output logic cout
);
  logic [5:0][31:0] g;
  logic [4:0][31:0] p;
  logic unused_p;
  assign p[0] = a ^ b;
  assign g[0] = (a & b) | {31'b0, p[0][0] & cin};
  for (genvar l = 0; l < 5; l++) begin : g_lvl
    for (genvar i = 0; i < 32; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_op
        assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
        if (l < 4) begin : g_p
          assign p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
        end
      end else begin : g_pass
        assign g[l+1][i] = g[l][i];
        if (l < 4) begin : g_p
          assign p[l+1][i] = p[l][i];
        end
      end
    end
  end
  // low group-propagates of the last level are resolved already
  assign unused_p = ^p[4][15:0];
  assign y = p[0] ^ {g[5][30:0], cin};
  assign cout = g[5][31];
endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one 32-bit prefix adder among N_REQ requesters
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  adder_share_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);
  if (WIDTH != ADD_W) begin : g_bad_width
    $error("adder_share_arbiter: WIDTH must equal the adder width");
  end
  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
    $error("adder_share_arbiter: N_REQ must be 2..16");
  end
  state_t state, nxt;
  add_op_t op;
  logic [ID_W-1:0] rr_ptr, gidx, op_id, res_id;
  logic [N_REQ-1:0] grant;
  logic [ADD_W-1:0] y, res_sum;
  logic cout, res_cout, win, xfer;
  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
    .req(bus.req_valid), .ptr(rr_ptr), .grant(grant), .grant_idx(gidx)
  );
  prefix_adder_32bit u_add (.cin(op.cin), .a(op.a), .b(op.b), .y(y), .cout(cout));
  // a new op may enter while the previous response is being consumed
  always_comb begin
    win = !rst && (state == IDLE || (state == RESP && bus.rsp_ready));
    xfer = win && |bus.req_valid;
    bus.req_ready = win ? grant : '0;
    bus.rsp_valid = state == RESP;
    nxt = state == EXEC ? RESP : (state == RESP && !bus.rsp_ready) ? RESP : xfer ? EXEC : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= ID_W'(N_REQ - 1);
      op <= '0;
      op_id <= '0;
      res_id <= '0;
      res_sum <= '0;
      res_cout <= 1'b0;
    end else begin
      state <= nxt;
      if (xfer) begin
        rr_ptr <= gidx;
        op_id <= gidx;
        op <= {bus.req_a[int'(gidx)*WIDTH +: WIDTH], bus.req_b[int'(gidx)*WIDTH +: WIDTH], bus.req_cin[gidx]};
      end
      if (state == EXEC) begin
        res_id <= op_id;
        res_sum <= y;
        res_cout <= cout;
      end
    end
  end
  assign bus.rsp_id = res_id;
  assign bus.rsp_sum = res_sum;
  assign bus.rsp_cout = res_cout;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed stimulus with a scoreboard of expected responses
module tb_adder_share_arbiter;
  import adder_share_pkg::*;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  adder_share_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
  adder_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  int pass_n = 0;
  int total_n = 0;
  int cyc = 0;
  int tb_ptr = N - 1;
  logic [34:0] exp_q[$];
  int got_id[$];
  int got_t[$];
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  function automatic logic [32:0] add33(input int i);
    return {1'b0, bus.req_a[i*W +: W]} + {1'b0, bus.req_b[i*W +: W]} + 33'(bus.req_cin[i]);
  endfunction
  // scoreboard: retire completed responses, then record newly accepted ops
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      chk("rsp_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("rsp_data", {bus.rsp_id, bus.rsp_cout, bus.rsp_sum}, exp_q.pop_front());
      got_id.push_back(int'(bus.rsp_id));
      got_t.push_back(cyc);
    end
    if (!rst && |bus.req_ready) begin
      int g;
      g = rr_pick(bus.req_valid, tb_ptr);
      chk("grant", bus.req_ready, g < 0 ? 0 : (1 << g));
      if (g >= 0) begin
        exp_q.push_back({2'(g), add33(g)});
        tb_ptr = g;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
    bus.req_valid[i] = 1'b1;
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_cin[i] = c;
  endtask
  task automatic wait_grant(input string tag, input logic [N-1:0] exp);
    int n = 0;
    @(negedge clk);
    while (bus.req_ready == 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.req_ready, exp);
    tick();
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain", exp_q.size(), 0);
    tick();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    tb_ptr = N - 1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_cin = '0;
    bus.rsp_ready = 1'b1;
    drive(0, 32'd5, 32'd7, 1'b1);
    tick();
    @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_regs", {bus.rsp_id, bus.rsp_cout, bus.rsp_sum}, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("single_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    chk("single_exec_idle_rsp", bus.rsp_valid, 0);
    @(negedge clk);
    chk("single_rsp_valid", bus.rsp_valid, 1);
    chk("single_sum", {bus.rsp_id, bus.rsp_cout, bus.rsp_sum}, {2'd0, 1'b0, 32'd13});
    drain();
    drive(0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_grant("ovf1_grant", 4'b0001);
    bus.req_valid[0] = 1'b0;
    drain();
    drive(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_grant("ovf2_grant", 4'b0001);
    bus.req_valid[0] = 1'b0;
    drain();
    do_reset();
    got_id.delete();
    got_t.delete();
    for (int i = 0; i < N; i++) drive(i, 32'h1111_0000 * (i + 1) + i, 32'hF0F0_0F0F ^ i, i[0]);
    for (int n = 0; n < 60 && got_id.size() < 6; n++) tick();
    bus.req_valid = '0;
    chk("fair_count", got_id.size() >= 6, 1);
    for (int k = 0; k < 6 && k < got_id.size(); k++) chk("fair_id", got_id[k], k % N);
    for (int k = 1; k < 6 && k < got_t.size(); k++) chk("fair_gap", got_t[k] - got_t[k-1], 2);
    drain();
    bus.rsp_ready = 1'b0;
    drive(1, 32'd1000, 32'd2000, 1'b0);
    wait_grant("bp_grant", 4'b0010);
    bus.req_valid[1] = 1'b0;
    tick();
    drive(2, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_hold", {bus.rsp_id, bus.rsp_cout, bus.rsp_sum}, {2'd1, 1'b0, 32'd3000});
      chk("bp_ready", bus.req_ready, 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_same_cycle", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid[2] = 1'b0;
    drain();
    drive(2, 32'd40, 32'd2, 1'b0);
    wait_grant("ptr_first", 4'b0100);
    bus.req_valid[2] = 1'b0;
    drive(1, 32'd11, 32'd22, 1'b0);
    drive(3, 32'd33, 32'd44, 1'b1);
    wait_grant("ptr_req3_first", 4'b1000);
    bus.req_valid[3] = 1'b0;
    wait_grant("ptr_req1_next", 4'b0010);
    bus.req_valid[1] = 1'b0;
    drain();
    drive(0, 32'd9, 32'd9, 1'b0);
    wait_grant("ar_grant", 4'b0001);
    bus.req_valid[0] = 1'b0;
    #1 rst = 1'b1;
    exp_q.delete();
    tb_ptr = N - 1;
    #1 chk("ar_rsp_valid_low", bus.rsp_valid, 0);
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("ar_no_rsp", bus.rsp_valid, 0);
    end
    tick();
    drive(1, 32'd123456, 32'd654321, 1'b1);
    wait_grant("ar_next_grant", 4'b0010);
    bus.req_valid[1] = 1'b0;
    drain();
    chk("final_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
